// File: rtl/operand_issue_stage_if.sv
// Handshake and operand bus bundle for operand_issue_stage.
// master drives decode/forwarding inputs and out_ready; slave is the stage itself.
interface operand_issue_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned REG_AW  = 5
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [REG_AW-1:0]           rs_addr;
  logic [REG_AW-1:0]           rt_addr;
  logic                        rs_use;
  logic                        rt_use;
  logic [DATA_W-1:0]           rs_data;
  logic [DATA_W-1:0]           rt_data;
  logic [DATA_W-1:0]           pc;
  logic [15:0]                 imm;
  logic [1:0]                  imm_mode;
  logic [1:0]                  alu_src;
  logic [NUM_FWD-1:0]          fwd_valid;
  logic [NUM_FWD-1:0]          fwd_pending;
  logic [NUM_FWD*REG_AW-1:0]   fwd_addr;
  logic [NUM_FWD*DATA_W-1:0]   fwd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           busa;
  logic [DATA_W-1:0]           busb;
  logic [DATA_W-1:0]           store_data;

  modport master (
    output flush, in_valid, rs_addr, rt_addr, rs_use, rt_use, rs_data, rt_data,
           pc, imm, imm_mode, alu_src, fwd_valid, fwd_pending, fwd_addr, fwd_data,
           out_ready,
    input  in_ready, out_valid, busa, busb, store_data
  );

  modport slave (
    input  flush, in_valid, rs_addr, rt_addr, rs_use, rt_use, rs_data, rt_data,
           pc, imm, imm_mode, alu_src, fwd_valid, fwd_pending, fwd_addr, fwd_data,
           out_ready,
    output in_ready, out_valid, busa, busb, store_data
  );
endinterface

// File: rtl/operand_issue_stage.sv
// Operand select stage: priority forwarding, immediate extension, ALU bus mux, load-use
// hazard and a one-entry valid/ready output register. OPSEL_STALL_CNT_EN adds stall_cnt.
module operand_issue_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_issue_stage_if.slave  bus
`ifdef OPSEL_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned IMM_W = 16;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_busa;
  logic [DATA_W-1:0] r_busb;
  logic [DATA_W-1:0] r_store_data;

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_rs_pend;
  logic              w_rt_pend;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_busa;
  logic [DATA_W-1:0] w_busb;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_capture;

  // Scan from oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    w_rs_val  = bus.rs_data;
    w_rs_pend = 1'b0;
    w_rt_val  = bus.rt_data;
    w_rt_pend = 1'b0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (bus.fwd_valid[i] && (bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rs_addr)) begin
        w_rs_val  = bus.fwd_data[i*DATA_W +: DATA_W];
        w_rs_pend = bus.fwd_pending[i];
      end
      if (bus.fwd_valid[i] && (bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rt_addr)) begin
        w_rt_val  = bus.fwd_data[i*DATA_W +: DATA_W];
        w_rt_pend = bus.fwd_pending[i];
      end
    end
    if (bus.rs_addr == '0) begin
      w_rs_val  = '0;
      w_rs_pend = 1'b0;
    end
    if (bus.rt_addr == '0) begin
      w_rt_val  = '0;
      w_rt_pend = 1'b0;
    end
  end

  always_comb begin
    w_ext = '0;
    unique case (bus.imm_mode)
      2'b00:   w_ext = DATA_W'(bus.imm);
      2'b01:   w_ext = {{(DATA_W-IMM_W){bus.imm[15]}}, bus.imm};
      2'b10:   w_ext = DATA_W'({bus.imm, 16'h0000});
      default: w_ext = DATA_W'(bus.imm[10:6]);
    endcase
  end

  always_comb begin
    w_busa = w_rs_val;
    w_busb = w_rt_val;
    unique case (bus.alu_src)
      2'b00:   begin w_busa = w_rs_val; w_busb = w_rt_val; end
      2'b01:   begin w_busa = w_rs_val; w_busb = w_ext;    end
      2'b10:   begin w_busa = w_ext;    w_busb = w_rt_val; end
      default: begin w_busa = bus.pc;   w_busb = w_ext;    end
    endcase
  end

  assign w_hazard   = (bus.rs_use && w_rs_pend) || (bus.rt_use && w_rt_pend);
  assign w_in_ready = !bus.flush && !w_hazard && ((r_state == ST_EMPTY) || bus.out_ready);
  assign w_capture  = bus.in_valid && w_in_ready;

  // Output register and occupancy FSM; flush overrides any capture or release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_busa       <= '0;
      r_busb       <= '0;
      r_store_data <= '0;
    end else if (bus.flush) begin
      r_state <= ST_EMPTY;
    end else if (w_capture) begin
      r_state      <= ST_FULL;
      r_busa       <= w_busa;
      r_busb       <= w_busb;
      r_store_data <= w_rt_val;
    end else if (bus.out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

`ifdef OPSEL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles an offered operation is held back by a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.in_valid && w_hazard && !bus.flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == ST_FULL);
  assign bus.busa       = r_busa;
  assign bus.busb       = r_busb;
  assign bus.store_data = r_store_data;

endmodule
